trig_lut_sequencer: RTL and testbench

Front-end controller for the trigonometric LUT bank (sine, cosine and tangent LUTs). It accepts one request at a time over a valid/ready handshake: an integer angle in degrees (0–359) and a function select. It range-reduces the angle to a quadrant and a 0–90 reference angle, enables exactly one LUT for one cycle, and captures that LUT's registered 64-bit IEEE-754 double result. It then returns the result over a valid/ready output handshake.

---
 rtl/trig_lut_sequencer.sv | 178 +++++++++++++++++
 tb/tb_trig_lut_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_lut_sequencer.sv
// Sequences one trig request at a time: range-reduce, pulse one LUT enable, capture its registered result.
// Latency: legal request k+3 cycles (k = 0..3 reduction steps), illegal request 1 cycle, from accept to out_valid.
// Backpressure: result is held in DONE until out_ready; in_ready is low from the accept cycle until back in IDLE.
module trig_lut_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ANGLE_W    = DATA_WIDTH,
    parameter int RESULT_W   = 2 * ANGLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ANGLE_W-1:0]  in_angle,
    input  logic [1:0]          in_func,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_data,
    output logic                out_err,
    output logic                en_sine,
    output logic                en_cosine,
    output logic                en_tangent,
    output logic [1:0]          lut_quadrant,
    output logic [ANGLE_W-1:0]  lut_angle,
    input  logic [RESULT_W-1:0] sine_data,
    input  logic [RESULT_W-1:0] cosine_data,
    input  logic [RESULT_W-1:0] tangent_data,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REDUCE  = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ANGLE_W-1:0] DEG_90  = ANGLE_W'(90);
    localparam logic [ANGLE_W-1:0] DEG_360 = ANGLE_W'(360);

    state_t              state_q, state_d;
    logic [ANGLE_W-1:0]  r_q, r_d;
    logic [1:0]          quad_q, quad_d;
    logic [1:0]          func_q, func_d;
    logic                err_q, err_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [2:0]          en_q, en_d;          // {tangent, cosine, sine}
    logic [1:0]          lut_quad_q, lut_quad_d;
    logic [ANGLE_W-1:0]  lut_angle_q, lut_angle_d;

    logic [ANGLE_W-1:0]  step_r;
    logic [1:0]          step_q;
    logic [RESULT_W-1:0] cap_data;

    // One-hot enable pattern for a function select; illegal select enables nothing.
    function automatic logic [2:0] func_enables(input logic [1:0] f);
        case (f)
            2'd0:    func_enables = 3'b001;
            2'd1:    func_enables = 3'b010;
            2'd2:    func_enables = 3'b100;
            default: func_enables = 3'b000;
        endcase
    endfunction

    // Next-state and datapath decisions. A reduction step and the hand-off to ISSUE share one cycle,
    // and angles already within 0..90 go straight from IDLE to ISSUE, so k steps cost exactly k cycles.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        quad_d      = quad_q;
        func_d      = func_q;
        err_d       = err_q;
        result_d    = result_q;
        en_d        = 3'b000;
        lut_quad_d  = lut_quad_q;
        lut_angle_d = lut_angle_q;
        step_r      = r_q - DEG_90;
        step_q      = quad_q + 2'd1;
        cap_data    = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    r_d    = in_angle;
                    quad_d = 2'd0;
                    func_d = in_func;
                    if (in_angle >= DEG_360 || in_func == 2'd3) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = S_DONE;
                    end else if (in_angle > DEG_90) begin
                        err_d   = 1'b0;
                        state_d = S_REDUCE;
                    end else begin
                        // Quadrant 0: reference angle is the angle itself.
                        err_d       = 1'b0;
                        lut_quad_d  = 2'd0;
                        lut_angle_d = in_angle;
                        en_d        = func_enables(in_func);
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_REDUCE: begin
                r_d    = step_r;
                quad_d = step_q;
                if (step_r <= DEG_90) begin
                    // Odd quadrants mirror the residue so the LUTs only ever see 0..90.
                    lut_quad_d  = step_q;
                    lut_angle_d = step_q[0] ? (DEG_90 - step_r) : step_r;
                    en_d        = func_enables(func_q);
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                case (func_q)
                    2'd0:    cap_data = sine_data;
                    2'd1:    cap_data = cosine_data;
                    default: cap_data = tangent_data;
                endcase
                // A signed zero from the LUT (e.g. tan 180, cos 270) is returned as +0.0.
                if (cap_data[RESULT_W-2:0] == '0) begin
                    cap_data[RESULT_W-1] = 1'b0;
                end
                result_d = cap_data;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any request in flight and clears every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            quad_q      <= 2'd0;
            func_q      <= 2'd0;
            err_q       <= 1'b0;
            result_q    <= '0;
            en_q        <= 3'b000;
            lut_quad_q  <= 2'd0;
            lut_angle_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            quad_q      <= quad_d;
            func_q      <= func_d;
            err_q       <= err_d;
            result_q    <= result_d;
            en_q        <= en_d;
            lut_quad_q  <= lut_quad_d;
            lut_angle_q <= lut_angle_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_data     = result_q;
    assign out_err      = err_q;
    assign en_sine      = en_q[0];
    assign en_cosine    = en_q[1];
    assign en_tangent   = en_q[2];
    assign lut_quadrant = lut_quad_q;
    assign lut_angle    = lut_angle_q;

endmodule

// File: tb/tb_trig_lut_sequencer.sv
// Bench for trig_lut_sequencer: behavioural LUT bank, cycle model of request/response timing, directed and random stimulus.
// Latency: model tracks accept-to-valid as k+3 (legal) or 1 (illegal) cycles.
// Backpressure: out_ready is held low and randomised; the model keeps results pending until the handshake.
module tb_trig_lut_sequencer;

    localparam real PI = 3.141592653589793;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_angle;
    logic [1:0]  in_func;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_err;
    logic        en_sine, en_cosine, en_tangent;
    logic [1:0]  lut_quadrant;
    logic [31:0] lut_angle;
    logic [63:0] sine_data, cosine_data, tangent_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    trig_lut_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle), .in_func(in_func),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .en_sine(en_sine), .en_cosine(en_cosine), .en_tangent(en_tangent),
        .lut_quadrant(lut_quadrant), .lut_angle(lut_angle),
        .sine_data(sine_data), .cosine_data(cosine_data), .tangent_data(tangent_data),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // LUT contents: magnitude of f(ref) for ref in 0..90, sign by quadrant; exact zeros at the axis points.
    function automatic logic [63:0] lut_val(input int fn, input int q, input int ref_a);
        real rad, mag;
        logic [63:0] b;
        bit neg;
        rad = ref_a * PI / 180.0;
        case (fn)
            0:       mag = (ref_a == 0)  ? 0.0 : $sin(rad);
            1:       mag = (ref_a == 90) ? 0.0 : $cos(rad);
            default: mag = (ref_a == 0)  ? 0.0 : $tan(rad);
        endcase
        case (fn)
            0:       neg = (q >= 2);
            1:       neg = (q == 1 || q == 2);
            default: neg = (q % 2 == 1);
        endcase
        b = $realtobits(mag);
        if (neg) b[63] = ~b[63];
        return b;
    endfunction

    // LUT bank: registers on its enable, drives only the cycle after, high-Z otherwise.
    logic [63:0] sin_q, cos_q, tan_q;
    bit sin_v = 1'b0, cos_v = 1'b0, tan_v = 1'b0;
    always @(posedge clk) begin
        sin_v <= en_sine;
        cos_v <= en_cosine;
        tan_v <= en_tangent;
        if (en_sine)    sin_q <= lut_val(0, int'(lut_quadrant), int'(lut_angle));
        if (en_cosine)  cos_q <= lut_val(1, int'(lut_quadrant), int'(lut_angle));
        if (en_tangent) tan_q <= lut_val(2, int'(lut_quadrant), int'(lut_angle));
    end
    assign sine_data    = sin_v ? sin_q : 64'bz;
    assign cosine_data  = cos_v ? cos_q : 64'bz;
    assign tangent_data = tan_v ? tan_q : 64'bz;

    // Enable pulse monitor: counts pulses and records what the LUTs saw.
    int         en_pulses = 0;
    logic [1:0] last_q;
    logic [31:0] last_a;
    always @(negedge clk) begin
        if (en_sine || en_cosine || en_tangent) begin
            en_pulses++;
            last_q = lut_quadrant;
            last_a = lut_angle;
        end
    end

    // Reference model: one outstanding request, described by age since accept and expected result.
    bit          started = 1'b0, just_reset = 1'b0, busy_m = 1'b0, err_m = 1'b0;
    int          age = 0, lat_m = 0, fn_m = 0, q_m = 0, ref_m = 0;
    logic [63:0] data_m = '0;

    always @(negedge clk) begin
        bit issue;
        int unsigned a, r;
        if (started) begin
            chk("busy", 64'(busy), 64'(busy_m));
            chk("in_ready", 64'(in_ready), 64'(!busy_m));
            chk("out_valid", 64'(out_valid), 64'(busy_m && age >= lat_m));
            issue = busy_m && !err_m && (age == lat_m - 2);
            chk("en_sine", 64'(en_sine), 64'(issue && fn_m == 0));
            chk("en_cosine", 64'(en_cosine), 64'(issue && fn_m == 1));
            chk("en_tangent", 64'(en_tangent), 64'(issue && fn_m == 2));
            if (issue) begin
                chk("lut_quadrant", 64'(lut_quadrant), 64'(q_m));
                chk("lut_angle", 64'(lut_angle), 64'(ref_m));
            end
            if (busy_m && age >= lat_m) begin
                chk("out_data", out_data, data_m);
                chk("out_err", 64'(out_err), 64'(err_m));
            end
            if (just_reset) begin
                chk("rst_out_data", out_data, 64'd0);
                chk("rst_out_err", 64'(out_err), 64'd0);
                chk("rst_lut_quadrant", 64'(lut_quadrant), 64'd0);
                chk("rst_lut_angle", 64'(lut_angle), 64'd0);
            end
        end
        // Advance to the state after the coming rising edge.
        just_reset = 1'b0;
        if (reset) begin
            busy_m = 1'b0;
            started = 1'b1;
            just_reset = 1'b1;
        end else if (started) begin
            if (!busy_m) begin
                if (in_valid) begin
                    busy_m = 1'b1;
                    age = 1;
                    a = in_angle;
                    fn_m = int'(in_func);
                    err_m = (a >= 360) || (fn_m == 3);
                    if (err_m) begin
                        lat_m = 1;
                        data_m = '0;
                    end else begin
                        q_m = (a == 0) ? 0 : int'((a - 1) / 90);
                        r = a - 90 * q_m;
                        ref_m = (q_m % 2 == 1) ? int'(90 - r) : int'(r);
                        lat_m = q_m + 3;
                        data_m = lut_val(fn_m, q_m, ref_m);
                        if (data_m[62:0] == '0) data_m[63] = 1'b0;
                    end
                end
            end else if (age >= lat_m && out_ready) begin
                busy_m = 1'b0;
            end else begin
                age++;
            end
        end
    end

    // Directed request from IDLE with literal expectations; optionally stalls the consumer first.
    task automatic directed(input string nm, input int ang, input int fn, input logic [63:0] exp_d,
                            input bit exp_e, input int exp_lat, input int exp_q, input int exp_ref,
                            input int hold);
        int lat, p0;
        logic [63:0] held;
        p0 = en_pulses;
        in_valid = 1'b1; in_angle = 32'(ang); in_func = 2'(fn); out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_angle = $urandom; in_func = 2'($urandom_range(0, 3));
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_data"}, out_data, exp_d);
        chk({nm, "_err"}, 64'(out_err), 64'(exp_e));
        chk({nm, "_pulses"}, 64'(en_pulses - p0), 64'(exp_e ? 0 : 1));
        if (!exp_e) begin
            chk({nm, "_quadrant"}, 64'(last_q), 64'(exp_q));
            chk({nm, "_ref"}, 64'(last_a), 64'(exp_ref));
        end
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_data"}, out_data, held);
            chk({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int p0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_angle = '0; in_func = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        directed("tan45",  45,  2, 64'h3fefffffffffffff, 1'b0, 3, 0, 45, 0);
        directed("tan135", 135, 2, 64'hbfefffffffffffff, 1'b0, 4, 1, 45, 0);
        directed("tan359", 359, 2, 64'hbf91dfbd9410a422, 1'b0, 6, 3, 1,  5);
        directed("tan180", 180, 2, 64'h0000000000000000, 1'b0, 4, 1, 0,  0);
        directed("cos270", 270, 1, 64'h0000000000000000, 1'b0, 5, 2, 90, 0);
        directed("sin90",  90,  0, 64'h3ff0000000000000, 1'b0, 3, 0, 90, 0);
        directed("err400", 400, 0, 64'h0, 1'b1, 1, 0, 0, 0);
        directed("errfn3", 10,  3, 64'h0, 1'b1, 1, 0, 0, 0);

        // Reset while reducing: everything returns to reset values and no enable follows.
        in_valid = 1'b1; in_angle = 32'd300; in_func = 2'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        p0 = en_pulses;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_in_ready", 64'(in_ready), 64'd1);
        chk("rstmid_out_valid", 64'(out_valid), 64'd0);
        chk("rstmid_enables", 64'({en_sine, en_cosine, en_tangent}), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("rstmid_no_pulse", 64'(en_pulses - p0), 64'd0);
        chk("rstmid_still_idle", 64'(out_valid), 64'd0);

        // Random traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_func   = 2'($urandom_range(0, 3));
            out_ready = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 9))
                0:       in_angle = $urandom;
                1:       in_angle = 32'($urandom_range(360, 1000));
                2:       in_angle = 32'($urandom_range(0, 4) * 90);
                default: in_angle = 32'($urandom_range(0, 359));
            endcase
            @(posedge clk); #1;
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
